// File: rtl/l1_bus_arb.sv
// l1_bus_arb: arbitrates L1i refill reads, L1d refill reads and L1d stores onto the
// single core bus. Only one bus transaction is outstanding at a time.
//
// Ports:
//   clk, rst                     core clock, asynchronous active-high reset
//   i_addr/i_rd/i_rdata/i_dv     L1i refill request (level) and completion pulse
//   d_addr/d_ext/d_rd/d_wr/
//   d_wdata/d_len/d_rdata/d_dv   L1d refill/store request (level) and completion pulse
//   lock_req/lock_ack            dmem atomic bus lock handshake
//   c_addr/c_ext/c_rd/c_wr/
//   c_wdata/c_len/c_rdata/c_dv   core bus; strobes are level, c_dv is a 1-cycle pulse
//   bus_err                      (ARB_TIMEOUT_EN only) 1-cycle pulse on bus timeout
//
// Build option: define ARB_TIMEOUT_EN to add a 16-bit watchdog that aborts a serving
// transaction when c_dv never arrives.
module l1_bus_arb #(
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       i_addr,
  input  logic              i_rd,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_dv,
  input  logic [63:0]       d_addr,
  input  logic              d_ext,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [63:0]       d_wdata,
  input  logic [1:0]        d_len,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_dv,
  input  logic              lock_req,
  output logic              lock_ack,
  output logic [63:0]       c_addr,
  output logic              c_ext,
  output logic              c_rd,
  output logic              c_wr,
  output logic [63:0]       c_wdata,
  output logic [1:0]        c_len,
  input  logic [LINE_W-1:0] c_rdata,
`ifdef ARB_TIMEOUT_EN
  output logic              bus_err,
`endif
  input  logic              c_dv
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StGap  = 3'd1,
    StRdI  = 3'd2,
    StRdD  = 3'd3,
    StWrD  = 3'd4
  } state_e;

  // rr_last encoding: which side completed the most recent unlocked transaction
  localparam logic RrI = 1'b0;
  localparam logic RrD = 1'b1;

  state_e      state_q, state_d;
  logic        rr_last_q, rr_last_d;
  logic        gap_i_q, gap_i_d;     // current GAP follows an RD_I transaction
  logic        lock_ack_q, lock_ack_d;
  logic [63:0] c_addr_q, c_addr_d;
  logic [63:0] c_wdata_q, c_wdata_d;
  logic [1:0]  c_len_q, c_len_d;
  logic        c_ext_q, c_ext_d;
  logic        c_rd_q, c_rd_d;
  logic        c_wr_q, c_wr_d;

  logic serving;
  logic to_hit;
  logic done;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic idle_grant_i;

  assign serving = (state_q == StRdI) || (state_q == StRdD) || (state_q == StWrD);

`ifdef ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  assign to_hit  = serving && (to_cnt_q == 16'hFFFF) && !c_dv;
  assign bus_err = to_hit;
`else
  assign to_hit = 1'b0;
`endif

  assign done = serving && (c_dv || to_hit);

  // I loses to D only when I was served last; I is stalled entirely while locked.
  assign d_req        = d_rd || d_wr;
  assign grant_i      = i_rd && !lock_ack_q && (!d_req || (rr_last_q == RrD));
  assign grant_d      = d_req && !grant_i;
  assign idle_grant_i = (state_q == StIdle) && grant_i;

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    gap_i_d   = gap_i_q;
    c_addr_d  = c_addr_q;
    c_wdata_d = c_wdata_q;
    c_len_d   = c_len_q;
    c_ext_d   = c_ext_q;
    c_rd_d    = c_rd_q;
    c_wr_d    = c_wr_q;
`ifdef ARB_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (grant_i) begin
          state_d  = StRdI;
          c_rd_d   = 1'b1;
          c_addr_d = i_addr;
          c_ext_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else if (grant_d) begin
          c_addr_d = d_addr;
          c_ext_d  = d_ext;
          // Stores go first so they stay ordered ahead of a pending refill.
          if (d_wr) begin
            state_d   = StWrD;
            c_wr_d    = 1'b1;
            c_wdata_d = d_wdata;
            c_len_d   = d_len;
          end else begin
            state_d = StRdD;
            c_rd_d  = 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end

      StRdI, StRdD, StWrD: begin
        if (done) begin
          state_d = StGap;
          c_rd_d  = 1'b0;
          c_wr_d  = 1'b0;
          gap_i_d = (state_q == StRdI);
          if (!lock_ack_q) begin
            rr_last_d = (state_q == StRdI) ? RrI : RrD;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          to_cnt_d = to_cnt_q + 16'd1;
`endif
        end
      end

      StGap: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        c_rd_d  = 1'b0;
        c_wr_d  = 1'b0;
      end
    endcase

    // Never acknowledge a lock while an I refill owns the bus, including the cycle an
    // I grant is being taken, so lock_ack cannot rise under an I transaction.
    lock_ack_d = lock_req && (state_q != StRdI) && !((state_q == StGap) && gap_i_q) &&
                 !idle_grant_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_last_q  <= RrD;
      gap_i_q    <= 1'b0;
      lock_ack_q <= 1'b0;
      c_addr_q   <= '0;
      c_wdata_q  <= '0;
      c_len_q    <= '0;
      c_ext_q    <= 1'b0;
      c_rd_q     <= 1'b0;
      c_wr_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      gap_i_q    <= gap_i_d;
      lock_ack_q <= lock_ack_d;
      c_addr_q   <= c_addr_d;
      c_wdata_q  <= c_wdata_d;
      c_len_q    <= c_len_d;
      c_ext_q    <= c_ext_d;
      c_rd_q     <= c_rd_d;
      c_wr_q     <= c_wr_d;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign c_addr   = c_addr_q;
  assign c_wdata  = c_wdata_q;
  assign c_len    = c_len_q;
  assign c_ext    = c_ext_q;
  assign c_rd     = c_rd_q;
  assign c_wr     = c_wr_q;
  assign lock_ack = lock_ack_q;

  assign i_dv    = (state_q == StRdI) && done;
  assign d_dv    = ((state_q == StRdD) || (state_q == StWrD)) && done;
  // Read data is a pass-through; only meaningful while the matching dv is high.
  assign i_rdata = c_rdata;
  assign d_rdata = c_rdata;

endmodule

// File: tb/tb_l1_bus_arb.sv
// Scoreboard bench for l1_bus_arb: a transaction-level model predicts the order and
// contents of bus transactions; a monitor compares each strobe and completion.
module tb_l1_bus_arb;

  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   i_addr = '0;
  logic          i_rd = 1'b0;
  logic [LW-1:0] i_rdata;
  logic          i_dv;
  logic [63:0]   d_addr = '0;
  logic          d_ext = 1'b0;
  logic          d_rd = 1'b0;
  logic          d_wr = 1'b0;
  logic [63:0]   d_wdata = '0;
  logic [1:0]    d_len = '0;
  logic [LW-1:0] d_rdata;
  logic          d_dv;
  logic          lock_req = 1'b0;
  logic          lock_ack;
  logic [63:0]   c_addr;
  logic          c_ext;
  logic          c_rd;
  logic          c_wr;
  logic [63:0]   c_wdata;
  logic [1:0]    c_len;
  logic [LW-1:0] c_rdata = '0;
  logic          c_dv = 1'b0;

  l1_bus_arb #(.LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rd(i_rd), .i_rdata(i_rdata), .i_dv(i_dv),
    .d_addr(d_addr), .d_ext(d_ext), .d_rd(d_rd), .d_wr(d_wr), .d_wdata(d_wdata),
    .d_len(d_len), .d_rdata(d_rdata), .d_dv(d_dv),
    .lock_req(lock_req), .lock_ack(lock_ack),
    .c_addr(c_addr), .c_ext(c_ext), .c_rd(c_rd), .c_wr(c_wr), .c_wdata(c_wdata),
    .c_len(c_len), .c_rdata(c_rdata), .c_dv(c_dv)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          side_d;
    bit          wr;
    bit          ext;
    bit          first;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  len;
    int          exp_cyc;
  } txn_t;

  txn_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            last_dv = -100;
  bit            rr_m = 1'b1;     // model: 1 = D side served last
  bit            resp_en = 1'b1;
  logic [LW-1:0] bus_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus responder: completes each strobe after a random 0..5 cycle latency.
  initial begin
    int cnt = 0;
    int lat = 2;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        c_dv = 1'b0;
        cnt  = 0;
      end else if (c_dv) begin
        c_dv = 1'b0;
      end else if (resp_en && (c_rd || c_wr)) begin
        if (cnt >= lat) begin
          bus_data = {8{$urandom()}};
          c_rdata  = bus_data;
          c_dv     = 1'b1;
          cnt      = 0;
          lat      = $urandom_range(0, 5);
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: compares every strobe and every completion against the scoreboard.
  initial begin
    bit   prev_strobe = 1'b0;
    bit   chk_drop = 1'b0;
    bit   strobe;
    txn_t t;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_strobe = 1'b0;
        chk_drop    = 1'b0;
      end else begin
        strobe = c_rd || c_wr;
        if (chk_drop) begin
          check("strobe_drop_after_dv", {255'd0, strobe}, 256'd0);
          chk_drop = 1'b0;
        end
        if (strobe && !prev_strobe) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: got c_rd=%0b c_wr=%0b addr=%0h expected none",
                     c_rd, c_wr, c_addr);
          end else begin
            t = exp_q[0];
            check("c_wr", {255'd0, c_wr}, {255'd0, t.wr});
            check("c_rd", {255'd0, c_rd}, {255'd0, !t.wr});
            check("c_addr", {192'd0, c_addr}, {192'd0, t.addr});
            check("c_ext", {255'd0, c_ext}, {255'd0, t.ext});
            if (t.wr) begin
              check("c_wdata", {192'd0, c_wdata}, {192'd0, t.wdata});
              check("c_len", {254'd0, c_len}, {254'd0, t.len});
            end
            check("strobe_cycle", 256'(cyc), 256'(t.first ? t.exp_cyc : last_dv + 3));
          end
        end
        if (i_dv || d_dv) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_dv: got i_dv=%0b d_dv=%0b expected none", i_dv, d_dv);
          end else begin
            t = exp_q.pop_front();
            check("i_dv", {255'd0, i_dv}, {255'd0, !t.side_d});
            check("d_dv", {255'd0, d_dv}, {255'd0, t.side_d});
            check("rdata", t.side_d ? d_rdata : i_rdata, bus_data);
          end
          last_dv  = cyc;
          chk_drop = 1'b1;
        end
        prev_strobe = strobe;
      end
    end
  end

  // Drive requests and predict the bus order: stores before D refills, and an I/D tie
  // goes to the side not served last; nothing updates the round-robin under lock.
  task automatic start_round(input bit di, input bit dw, input bit dr, input bit locked,
                             input logic [63:0] ia, input logic [63:0] da,
                             input logic [63:0] wd, input logic [1:0] ln, input bit ex);
    txn_t t;
    bit   pi, pw, pr, serve_i, first;
    i_addr = ia; d_addr = da; d_wdata = wd; d_len = ln; d_ext = ex;
    i_rd = di; d_wr = dw; d_rd = dr;
    pi = di && !locked; pw = dw; pr = dr; first = 1'b1;
    while (pi || pw || pr) begin
      serve_i   = (pi && (pw || pr)) ? rr_m : pi;
      t.first   = first;
      t.exp_cyc = cyc + 1;
      t.wdata   = wd;
      t.len     = ln;
      if (serve_i) begin
        t.side_d = 1'b0; t.wr = 1'b0; t.addr = ia; t.ext = 1'b0; pi = 1'b0;
      end else begin
        t.side_d = 1'b1; t.addr = da; t.ext = ex; t.wr = pw;
        if (pw) pw = 1'b0;
        else pr = 1'b0;
      end
      exp_q.push_back(t);
      if (!locked) rr_m = !serve_i;
      first = 1'b0;
    end
  endtask

  task automatic finish_round(input bit hold_i);
    int budget = 400;
    while ((exp_q.size() != 0 || (i_rd && !hold_i) || d_rd || d_wr) && budget > 0) begin
      @(negedge clk);
      if (i_dv) i_rd = 1'b0;
      if (d_dv) begin
        if (d_wr) d_wr = 1'b0;
        else d_rd = 1'b0;
      end
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL round_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_c_rd"}, {255'd0, c_rd}, 256'd0);
    check({tag, "_c_wr"}, {255'd0, c_wr}, 256'd0);
    check({tag, "_c_addr"}, {192'd0, c_addr}, 256'd0);
    check({tag, "_c_wdata"}, {192'd0, c_wdata}, 256'd0);
    check({tag, "_c_len"}, {254'd0, c_len}, 256'd0);
    check({tag, "_c_ext"}, {255'd0, c_ext}, 256'd0);
    check({tag, "_dv"}, {254'd0, i_dv, d_dv}, 256'd0);
    check({tag, "_lock_ack"}, {255'd0, lock_ack}, 256'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dvc;
    int budget;
    bit ri, rw, rr;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // I alone, then an I/D tie right after reset (I first), then store+refill together.
    start_round(1, 0, 0, 0, 64'h8000_0040, 64'h0, 64'h0, 2'd0, 1'b0);
    finish_round(1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_m = 1'b1;
    @(negedge clk);
    start_round(1, 0, 1, 0, 64'h8000_1000, 64'h9000_2000, 64'h0, 2'd0, 1'b1);
    finish_round(1'b0);
    start_round(0, 1, 1, 0, 64'h0, 64'h4000_0008, 64'hDEAD_BEEF, 2'd2, 1'b0);
    finish_round(1'b0);

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      ri = $urandom_range(0, 1); rw = $urandom_range(0, 1); rr = $urandom_range(0, 1);
      if (!ri && !rw && !rr) ri = 1'b1;
      start_round(ri, rw, rr, 0, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                  {$urandom(), $urandom()}, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
      finish_round(1'b0);
    end

    // Lock requested during an I refill: ack only once the refill and its GAP are over.
    start_round(1, 0, 0, 0, 64'h8000_0080, 64'h0, 64'h0, 2'd0, 1'b0);
    @(negedge clk);
    lock_req = 1'b1;
    dvc = -100;
    budget = 100;
    while (!lock_ack && budget > 0) begin
      if (i_dv) begin
        i_rd = 1'b0;
        dvc  = cyc;
      end
      @(negedge clk);
      budget--;
    end
    check("lock_ack_rise_cycle", 256'(cyc), 256'(dvc + 3));
    // A new I request is ignored while locked; a D store still goes through.
    i_addr = 64'h8000_00C0;
    i_rd   = 1'b1;
    repeat (10) @(negedge clk);
    check("lock_ack_held", {255'd0, lock_ack}, {255'd0, 1'b1});
    start_round(1, 1, 0, 1, 64'h8000_00C0, 64'h5000_0010, 64'h1234_5678, 2'd3, 1'b1);
    finish_round(1'b1);
    check("lock_ack_held_after_d", {255'd0, lock_ack}, {255'd0, 1'b1});
    i_rd = 1'b0;
    @(negedge clk);
    lock_req = 1'b0;
    @(negedge clk);
    check("lock_ack_release", {255'd0, lock_ack}, 256'd0);
    // Round-robin was frozen under lock: I served last, so D wins this tie.
    start_round(1, 0, 1, 0, 64'h8000_0100, 64'h6000_0020, 64'h0, 2'd0, 1'b0);
    finish_round(1'b0);

    // Asynchronous reset in the middle of a store.
    resp_en = 1'b0;
    start_round(0, 1, 0, 0, 64'h0, 64'h7000_0030, 64'hCAFE_F00D, 2'd1, 1'b1);
    @(negedge clk);
    check("wr_before_reset", {255'd0, c_wr}, {255'd0, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_c_wr", {255'd0, c_wr}, 256'd0);
    check("async_reset_d_dv", {255'd0, d_dv}, 256'd0);
    exp_q.delete();
    d_wr = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    rst = 1'b0;
    rr_m = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {254'd0, c_rd, c_wr}, 256'd0);
    start_round(1, 1, 0, 0, 64'h8000_0200, 64'h7000_0040, 64'h55AA, 2'd0, 1'b0);
    finish_round(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_bus_arb.md
Name: l1_bus_arb

Overview:
- Arbitrates L1i refill reads, L1d refill reads and L1d write-through stores onto the single core bus (c_addr/c_rd/c_wr/c_dv).
- Sits between the L1 caches and the bus interface; one transaction is outstanding at a time.
- Supports a dmem-side bus lock for atomic sequences.

Parameters:
LINE_W, 256, refill line width in bits (matches CMEM_LINE)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
i_addr  in  64  L1i refill address
i_rd  in  1  L1i refill request, level, held until i_dv
i_rdata  out  LINE_W  L1i refill data
i_dv  out  1  L1i refill done, 1-cycle pulse
d_addr  in  64  L1d address (read or write)
d_ext  in  1  uncached/external access flag
d_rd  in  1  L1d refill request, level
d_wr  in  1  L1d store request, level
d_wdata  in  64  store data
d_len  in  2  store size (0=B, 1=H, 2=W, 3=D)
d_rdata  out  LINE_W  L1d refill data
d_dv  out  1  L1d transaction done, 1-cycle pulse
lock_req  in  1  atomic lock request from dmem
lock_ack  out  1  lock granted
c_addr  out  64  bus address
c_ext  out  1  bus external flag
c_rd  out  1  bus read strobe, level
c_wr  out  1  bus write strobe, level
c_wdata  out  64  bus write data
c_len  out  2  bus write size
c_rdata  in  LINE_W  bus read data
c_dv  in  1  bus completion, 1-cycle pulse, for reads and writes

Behaviour:
- States: IDLE, GAP, RD_I, RD_D, WR_D.
- Reset (async, immediate): state=IDLE; c_rd=c_wr=0; c_addr=c_wdata=0; c_len=0; c_ext=0; i_dv=d_dv=0; lock_ack=0; rr_last=D.
- IDLE: evaluate requests in the same cycle; the next state is registered. Bus outputs are registered and driven from the first cycle of the serving state, so latency is request edge to strobe = 1 cycle.
- Arbitration, I vs D:
  - Round-robin on rr_last; the side not served last wins a tie.
  - rr_last updates when a transaction completes.
- Within D, d_wr has priority over d_rd to keep stores ordered.
- Address, wdata, len and ext are captured into registers on grant. Requester changes after grant are ignored.
- c_ext = d_ext for D transactions, 0 for I.
- Serving states: strobe held until c_dv=1.
  - On c_dv: the matching i_dv/d_dv pulses in the same cycle.
  - i_rdata/d_rdata = c_rdata (combinational pass-through, valid only while dv=1).
  - Strobe drops on the next edge; state goes to GAP.
- GAP: one mandatory bus-turnaround cycle with no strobe, then IDLE.
  - Back-to-back transactions: c_dv at cycle N, next strobe at N+3.
- A requester dropping its request mid-transaction is illegal. The arbiter completes the transaction regardless, and the dv pulse is still issued.
- Simultaneous d_rd and d_wr: the write is served first; d_dv pulses once per transaction.
- Lock:
  - lock_ack=1 once lock_req=1 and the state is not RD_I and not GAP-after-RD_I; registered, 1 cycle after the condition.
  - While lock_ack=1, only D requests are granted and I is stalled. lock_ack stays high until lock_req falls, then clears next cycle.
  - rr_last is not updated during lock.
- An unknown or illegal state recovers to IDLE.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- With the macro: a 16-bit counter runs in serving states and resets on each grant. At 0xFFFF without c_dv, the arbiter:
  - drops the strobe;
  - pulses the requester dv;
  - asserts output bus_err (1 bit, 1-cycle pulse, same cycle as dv);
  - goes to GAP.
- bus_err resets to 0.
- Without the macro: no counter and no bus_err port; the arbiter waits indefinitely.

Test Plan:
- I alone: i_rd=1, i_addr=0x8000_0040; bus answers c_dv 5 cycles after c_rd -> c_rd high 1 cycle after i_rd, c_addr=0x8000_0040, i_dv pulses with i_rdata=c_rdata, c_rd low next cycle.
- I and D tie after reset: i_rd=d_rd=1 -> I served first (rr_last=D), then D; D strobe 3 cycles after I's c_dv.
- D write and read together: d_wr=d_rd=1, d_len=2, d_wdata=0xDEADBEEF -> c_wr first with c_len=2, c_wdata=0xDEADBEEF, c_rd issued afterwards; two d_dv pulses.
- Lock during I refill: RD_I active, lock_req=1 -> lock_ack stays 0 until the I transaction completes and GAP ends. Then lock_ack=1, and a further i_rd is ignored while locked.
- Async reset mid-WR_D: rst pulsed between clock edges -> c_wr=0 immediately, no d_dv, state IDLE.
- ARB_TIMEOUT_EN: c_dv never returned -> after 65535 cycles bus_err and d_dv pulse together, c_rd drops.
